// File: rtl/glitc_intercom_align.sv
// glitc_intercom_align: bitslip training for the intercom nibble stream.
// The nibble arrives already retimed to sysclk. The block hunts for the one
// slip position where the stream equals TRAIN_PATTERN, pulses the ISERDES
// bitslip input as it searches, and reports either lock or failure. Once it
// is locked it forwards the nibbles downstream one cycle late.
//
// Optional feature: define GLITC_INTERCOM_ALIGN_MONITOR_EN to count pattern
// errors seen after lock on err_count_o. When the macro is not defined,
// err_count_o is tied to zero and no counter is built.
//
// Handshake: there is no ready. valid_o is high exactly when data_o holds an
// aligned nibble. That nibble is the one sampled on the previous sysclk edge.
// dbg_state_o exposes the FSM state so checkers can bind to it.
module glitc_intercom_align #(
  parameter logic [3:0] TRAIN_PATTERN = 4'hC,
  parameter int         CHECK_CYCLES  = 16,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MAX_SLIPS     = 3
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic [3:0]  oq_i,
  input  logic        train_i,
  output logic        bitslip_o,
  output logic        locked_o,
  output logic        fail_o,
  output logic [1:0]  slip_count_o,
  output logic [3:0]  data_o,
  output logic        valid_o,
  output logic [15:0] err_count_o,
  output logic [2:0]  dbg_state_o
);

  localparam int MW = $clog2(CHECK_CYCLES + 1);
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    slip_q, slip_d;
  logic          train_q;
  logic          locked_q, locked_d;
  logic [3:0]    data_q, data_d;
  logic          train_rise;
  logic          is_match;

  assign train_rise = train_i & ~train_q;
  assign is_match   = (oq_i == TRAIN_PATTERN);

  // Next-state logic and counter updates for the training FSM.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    wait_d  = wait_q;
    slip_d  = slip_q;
    case (state_q)
      ST_IDLE: begin
        if (train_i) begin
          state_d = ST_CHECK;
          match_d = '0;
          slip_d  = '0;
        end
      end
      ST_CHECK: begin
        // A dropped train request wins over the match result.
        if (!train_i) begin
          state_d = ST_IDLE;
        end else if (is_match) begin
          if (match_q == MW'(CHECK_CYCLES - 1)) begin
            state_d = ST_LOCKED;
          end else begin
            match_d = match_q + 1'b1;
          end
        end else if (slip_q == 2'(MAX_SLIPS)) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_SLIP;
          match_d = '0;
        end
      end
      ST_SLIP: begin
        // The pulse is always followed by the settle wait, even if training is dropped.
        slip_d  = slip_q + 1'b1;
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!train_i) begin
          state_d = ST_IDLE;
        end else if (wait_q == WW'(SLIP_WAIT - 1)) begin
          state_d = ST_CHECK;
          match_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_LOCKED, ST_FAIL: begin
        if (train_rise) begin
          state_d = ST_CHECK;
          match_d = '0;
          slip_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lock, and the forwarded data, become visible one edge after the FSM settles in LOCKED.
  // Both drop on the same edge that leaves LOCKED.
  always_comb begin
    locked_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    data_d   = locked_d ? oq_i : 4'h0;
  end

  // State and datapath registers; reset overrides everything, including a pending slip.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      match_q  <= '0;
      wait_q   <= '0;
      slip_q   <= '0;
      train_q  <= 1'b0;
      locked_q <= 1'b0;
      data_q   <= 4'h0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      wait_q   <= wait_d;
      slip_q   <= slip_d;
      train_q  <= train_i;
      locked_q <= locked_d;
      data_q   <= data_d;
    end
  end

`ifdef GLITC_INTERCOM_ALIGN_MONITOR_EN
  logic [15:0] err_q, err_d;

  // Count pattern errors while locked; the count saturates and is cleared on every entry to CHECK.
  always_comb begin
    err_d = err_q;
    if (state_d == ST_CHECK && state_q != ST_CHECK) begin
      err_d = '0;
    end else if (state_q == ST_LOCKED && train_i && !is_match && err_q != 16'hFFFF) begin
      err_d = err_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = 16'h0000;
`endif

  assign bitslip_o    = (state_q == ST_SLIP);
  assign fail_o       = (state_q == ST_FAIL);
  assign locked_o     = locked_q;
  assign valid_o      = locked_q;
  assign data_o       = data_q;
  assign slip_count_o = slip_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_glitc_intercom_align.sv
// Testbench for glitc_intercom_align: scenario tasks driven from one initial
// block, with a scoreboard queue for the forwarded data path.
module tb_glitc_intercom_align;

`ifdef GLITC_INTERCOM_ALIGN_MONITOR_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  localparam int CHECK_CYCLES = 16;
  localparam int SLIP_WAIT    = 4;

  logic        sysclk;
  logic        rst;
  logic [3:0]  oq;
  logic        train;
  logic        bitslip;
  logic        locked;
  logic        fail;
  logic [1:0]  slip_count;
  logic [3:0]  data;
  logic        valid;
  logic [15:0] err_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  glitc_intercom_align dut (
    .sysclk_i     (sysclk),
    .rst_i        (rst),
    .oq_i         (oq),
    .train_i      (train),
    .bitslip_o    (bitslip),
    .locked_o     (locked),
    .fail_o       (fail),
    .slip_count_o (slip_count),
    .data_o       (data),
    .valid_o      (valid),
    .err_count_o  (err_count),
    .dbg_state_o  (dbg_state)
  );

  // Clock and reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    train = 1'b0;
    oq    = 4'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Driver: run training until lock, failure or a cycle budget runs out.
  // When rotate is set, it models the ISERDES, which rotates the nibble one
  // position on the edge after each bitslip pulse.
  task automatic run_train(input int max_cyc, input bit rotate,
                           output int pulses, output int cycles, output int min_gap);
    bit pending;
    int last;
    pending = 1'b0;
    last    = -1000;
    pulses  = 0;
    cycles  = 0;
    min_gap = 1000;
    while (cycles < max_cyc) begin
      step();
      cycles++;
      if (pending) oq = {oq[2:0], oq[3]};
      pending = rotate && bitslip;
      if (bitslip) begin
        pulses++;
        if (cycles - last < min_gap) min_gap = cycles - last;
        last = cycles;
      end
      if (locked || fail) break;
    end
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    rst   = 1'b1;
    train = 1'b1;
    oq    = 4'hC;
    step();
    obs = {bitslip, locked, fail, valid, slip_count, data, err_count};
    checks++;
    if (obs !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", obs);
    end
    rst   = 1'b0;
    train = 1'b0;
    step();
  endtask

  task automatic test_aligned();
    int p, c, g;
    do_reset();
    train = 1'b1;
    oq    = 4'hC;
    run_train(60, 1'b0, p, c, g);
    checks++;
    if (locked !== 1'b1 || c != CHECK_CYCLES + 2) begin
      errors++;
      $display("FAIL aligned_lock_time got locked=%b cycles=%0d want 1 %0d", locked, c, CHECK_CYCLES + 2);
    end
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL aligned_pulses got %0d want 0", p);
    end
    checks++;
    if (slip_count !== 2'd0) begin
      errors++;
      $display("FAIL aligned_slip_count got %0d want 0", slip_count);
    end
  endtask

  task automatic test_two_slips();
    int p, c, g;
    logic [3:0] e;
    do_reset();
    train = 1'b1;
    oq    = 4'h3;
    run_train(120, 1'b1, p, c, g);
    checks++;
    if (locked !== 1'b1 || p != 2) begin
      errors++;
      $display("FAIL two_slip_lock got locked=%b pulses=%0d want 1 2", locked, p);
    end
    checks++;
    if (g < SLIP_WAIT + 2) begin
      errors++;
      $display("FAIL two_slip_gap got %0d want >= %0d", g, SLIP_WAIT + 2);
    end
    checks++;
    if (slip_count !== 2'd2) begin
      errors++;
      $display("FAIL two_slip_count got %0d want 2", slip_count);
    end
    // Scoreboard: each nibble driven is expected on data_o after the next edge.
    for (int i = 0; i < 12; i++) begin
      oq = 4'($urandom_range(0, 15));
      exp_q.push_back(oq);
      step();
      e = exp_q.pop_front();
      checks++;
      if (data !== e || valid !== 1'b1) begin
        errors++;
        $display("FAIL data_follow[%0d] got data=%h valid=%b want %h 1", i, data, valid, e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    oq = 4'hC;
  endtask

  task automatic test_never_match();
    int p, c, g;
    do_reset();
    train = 1'b1;
    oq    = 4'h5;
    run_train(120, 1'b0, p, c, g);
    checks++;
    if (p != 3 || fail !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL never_match got pulses=%0d fail=%b locked=%b want 3 1 0", p, fail, locked);
    end
    checks++;
    if (slip_count !== 2'd3) begin
      errors++;
      $display("FAIL never_match_count got %0d want 3", slip_count);
    end
    train = 1'b0;
    step();
    train = 1'b1;
    step();
    checks++;
    if (slip_count !== 2'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL fail_restart got slip=%0d fail=%b want 0 0", slip_count, fail);
    end
  endtask

  task automatic test_abort_and_reset();
    int p, n;
    logic [25:0] obs;
    do_reset();
    train = 1'b1;
    oq    = 4'h5;
    n = 0;
    while (!bitslip && n < 20) begin
      step();
      n++;
    end
    step();
    train = 1'b0;
    p = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bitslip) p++;
    end
    checks++;
    if (p != 0 || locked !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_wait got pulses=%0d locked=%b fail=%b want 0 0 0", p, locked, fail);
    end
    train = 1'b1;
    n = 0;
    while (!bitslip && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bitslip !== 1'b1) begin
      errors++;
      $display("FAIL reach_slip got bitslip=%b want 1", bitslip);
    end
    rst = 1'b1;
    step();
    obs = {bitslip, locked, fail, valid, slip_count, data, err_count};
    checks++;
    if (obs !== 26'h0) begin
      errors++;
      $display("FAIL reset_in_slip got %h want 0", obs);
    end
    rst   = 1'b0;
    train = 1'b0;
    step();
  endtask

  task automatic test_retrain();
    int p, c, g;
    do_reset();
    train = 1'b1;
    oq    = 4'hC;
    run_train(60, 1'b0, p, c, g);
    train = 1'b0;
    step();
    step();
    step();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL hold_lock_train_low got %b want 1", locked);
    end
    train = 1'b1;
    step();
    checks++;
    if (locked !== 1'b0 || valid !== 1'b0 || data !== 4'h0) begin
      errors++;
      $display("FAIL retrain_drop got locked=%b valid=%b data=%h want 0 0 0", locked, valid, data);
    end
    run_train(60, 1'b0, p, c, g);
    checks++;
    if (locked !== 1'b1 || c != CHECK_CYCLES + 1) begin
      errors++;
      $display("FAIL relock_time got locked=%b cycles=%0d want 1 %0d", locked, c, CHECK_CYCLES + 1);
    end
  endtask

  task automatic test_monitor();
    int p, c, g;
    logic [15:0] want;
    train = 1'b0;
    step();
    train = 1'b1;
    oq    = 4'hC;
    step();
    run_train(60, 1'b0, p, c, g);
    oq = 4'hA;
    step();
    oq = 4'h0;
    step();
    oq = 4'h3;
    step();
    oq = 4'hC;
    step();
    want = MON_EN ? 16'd3 : 16'd0;
    checks++;
    if (err_count !== want) begin
      errors++;
      $display("FAIL monitor_count got %0d want %0d", err_count, want);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL monitor_keeps_lock got %b want 1", locked);
    end
  endtask

  initial begin
    rst   = 1'b1;
    train = 1'b0;
    oq    = 4'h0;
    test_reset();
    test_aligned();
    test_two_slips();
    test_never_match();
    test_abort_and_reset();
    test_retrain();
    test_monitor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
